// File: rtl/otter_intr_ctrl.sv
// ---------------------------------------------------------------------------
// otter_intr_ctrl
//
// Interrupt/trap sequencer for the OTTER pipeline. Synchronizes the external
// interrupt line and takes the interrupt on an instruction-retire boundary in
// writeback. On a take it saves the return address, flushes the pipeline and
// redirects it to MTVEC. Further interrupts stay masked while the handler
// runs. A retired MRET redirects the pipeline back to MEPC.
//
// Ports
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   INTR         external interrupt request (asynchronous level)
//   CSR_MIE      interrupt enable from the CSR block
//   CSR_MTVEC    trap handler address
//   CSR_MEPC     return address used by MRET
//   WB_VALID     an instruction retires in writeback this cycle
//   WB_MRET      the retiring instruction is MRET (qualified by WB_VALID)
//   WB_PC_NEXT   architectural next PC of the retiring instruction
//   INT_TAKEN    one-cycle pulse; the CSR block captures MEPC from INT_PC
//   INT_PC       saved return address (holds until the next capture)
//   FLUSH        one-cycle pulse; kills everything younger than writeback
//   REDIRECT     one-cycle pulse; the PC loads REDIRECT_PC
//   REDIRECT_PC  redirect target, 0 when REDIRECT is low
//   IN_HANDLER   high while the handler executes
//
// State    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no interrupt in flight; stray MRETs are ignored here
// PEND     | enabled request seen, waiting for a retire to capture the PC
// TAKE     | one cycle: flush, redirect to MTVEC, pulse INT_TAKEN
// HANDLER  | handler running; request and MIE ignored (no nesting)
// RET      | one cycle: flush, redirect to MEPC
// ---------------------------------------------------------------------------
module otter_intr_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        INTR,
    input  logic        CSR_MIE,
    input  logic [31:0] CSR_MTVEC,
    input  logic [31:0] CSR_MEPC,
    input  logic        WB_VALID,
    input  logic        WB_MRET,
    input  logic [31:0] WB_PC_NEXT,
    output logic        INT_TAKEN,
    output logic [31:0] INT_PC,
    output logic        FLUSH,
    output logic        REDIRECT,
    output logic [31:0] REDIRECT_PC,
    output logic        IN_HANDLER
);

    // One-hot encoding: every control output is a single state bit (or an
    // OR of two bits that are never active on adjacent cycles), so the
    // outputs cannot glitch on state changes.
    localparam int S_IDLE    = 0;
    localparam int S_PEND    = 1;
    localparam int S_TAKE    = 2;
    localparam int S_HANDLER = 3;
    localparam int S_RET     = 4;

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        PEND    = 5'b00010,
        TAKE    = 5'b00100,
        HANDLER = 5'b01000,
        RET     = 5'b10000
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req;
    logic                   capture;

    // ---------------------------------------------------------------
    // INTR synchronizer
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], INTR};
        end
    end

    assign req = sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req && CSR_MIE) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                // A request drop or disable wins over a same-cycle retire.
                if (!req || !CSR_MIE) begin
                    state_d = IDLE;
                end else if (WB_VALID) begin
                    state_d = TAKE;
                end
            end
            TAKE: begin
                state_d = HANDLER;
            end
            HANDLER: begin
                if (WB_VALID && WB_MRET) begin
                    state_d = RET;
                end
            end
            RET: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Return-address capture: same condition as the PEND -> TAKE edge
    // ---------------------------------------------------------------
    assign capture = state_q[S_PEND] && req && CSR_MIE && WB_VALID;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            INT_PC <= '0;
        end else if (capture) begin
            INT_PC <= WB_PC_NEXT;
        end
    end

    // ---------------------------------------------------------------
    // Moore outputs decoded from the state register
    // ---------------------------------------------------------------
    assign INT_TAKEN   = state_q[S_TAKE];
    assign FLUSH       = state_q[S_TAKE] | state_q[S_RET];
    assign REDIRECT    = state_q[S_TAKE] | state_q[S_RET];
    assign IN_HANDLER  = state_q[S_HANDLER];
    assign REDIRECT_PC = ({32{state_q[S_TAKE]}} & CSR_MTVEC)
                       | ({32{state_q[S_RET]}}  & CSR_MEPC);

    // IDLE is implied by the absence of the other bits.
    logic unused_idle;
    assign unused_idle = state_q[S_IDLE];

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_otter_intr_ctrl
//
// Directed bench for otter_intr_ctrl (SYNC_STAGES = 2). Inputs are driven
// 1 ns after the rising edge and outputs are sampled there as well, so each
// sample reflects the state registered on the preceding edge.
// ---------------------------------------------------------------------------
module tb_otter_intr_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        INTR = 1'b0;
    logic        CSR_MIE = 1'b0;
    logic [31:0] CSR_MTVEC = '0;
    logic [31:0] CSR_MEPC = '0;
    logic        WB_VALID = 1'b0;
    logic        WB_MRET = 1'b0;
    logic [31:0] WB_PC_NEXT = '0;
    logic        INT_TAKEN;
    logic [31:0] INT_PC;
    logic        FLUSH;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        IN_HANDLER;

    int total = 0;
    int bad = 0;

    otter_intr_ctrl #(.SYNC_STAGES(2)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .INTR        (INTR),
        .CSR_MIE     (CSR_MIE),
        .CSR_MTVEC   (CSR_MTVEC),
        .CSR_MEPC    (CSR_MEPC),
        .WB_VALID    (WB_VALID),
        .WB_MRET     (WB_MRET),
        .WB_PC_NEXT  (WB_PC_NEXT),
        .INT_TAKEN   (INT_TAKEN),
        .INT_PC      (INT_PC),
        .FLUSH       (FLUSH),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .IN_HANDLER  (IN_HANDLER)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic t, input logic f, input logic r,
                            input logic [31:0] pc, input logic h);
        chk({tag, ".int_taken"},   32'(INT_TAKEN),  32'(t));
        chk({tag, ".flush"},       32'(FLUSH),      32'(f));
        chk({tag, ".redirect"},    32'(REDIRECT),   32'(r));
        chk({tag, ".redirect_pc"}, REDIRECT_PC,     pc);
        chk({tag, ".in_handler"},  32'(IN_HANDLER), 32'(h));
    endtask

    // n cycles with no pulses, no redirect target and not in the handler
    task automatic quiet(input string tag, input int n);
        int hits = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (INT_TAKEN || FLUSH || REDIRECT || IN_HANDLER || (REDIRECT_PC != 32'h0))
                hits++;
        end
        chk({tag, ".quiet_cycles"}, 32'(hits), 32'h0);
    endtask

    // From IDLE with req low: checks the edge-by-edge latency to HANDLER.
    task automatic run_take(input string tag, input logic [31:0] pc);
        INTR = 1'b1;
        WB_VALID = 1'b1;
        WB_PC_NEXT = pc;
        tick(); chk_outs({tag, ".e1"}, 0, 0, 0, 32'h0, 0);
        tick(); chk_outs({tag, ".e2"}, 0, 0, 0, 32'h0, 0);
        tick(); chk_outs({tag, ".e3_pend"}, 0, 0, 0, 32'h0, 0);
        tick(); chk_outs({tag, ".e4_take"}, 1, 1, 1, CSR_MTVEC, 0);
        chk({tag, ".int_pc"}, INT_PC, pc);
        WB_VALID = 1'b0;
        tick(); chk_outs({tag, ".e5_handler"}, 0, 0, 0, 32'h0, 1);
    endtask

    // From HANDLER: retire MRET, check RET then IDLE.
    task automatic run_ret(input string tag, input logic [31:0] mepc, input logic intr_lvl);
        INTR = intr_lvl;
        CSR_MEPC = mepc;
        WB_VALID = 1'b1;
        WB_MRET = 1'b1;
        tick(); chk_outs({tag, ".ret"}, 0, 1, 1, mepc, 0);
        WB_VALID = 1'b0;
        WB_MRET = 1'b0;
        tick(); chk_outs({tag, ".idle"}, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        int hits;

        // reset state
        #23;
        chk_outs("reset", 0, 0, 0, 32'h0, 0);
        chk("reset.int_pc", INT_PC, 32'h0);
        RST_N = 1'b1;
        tick();
        tick();

        // basic take with Timing-section latency
        CSR_MIE = 1'b1;
        CSR_MTVEC = 32'h0000_0100;
        run_take("basic", 32'h0000_2004);

        // handler ignores a toggling request and plain retires
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            INTR = i[0];
            WB_VALID = 1'b1;
            WB_MRET = 1'b0;
            WB_PC_NEXT = 32'h0000_5000 + 32'(i * 4);
            tick();
            if (INT_TAKEN || FLUSH || REDIRECT || !IN_HANDLER) hits++;
        end
        chk("handler.no_nest", 32'(hits), 32'h0);
        chk("handler.int_pc_kept", INT_PC, 32'h0000_2004);
        INTR = 1'b1;
        WB_VALID = 1'b0;
        tick(); tick(); tick();
        chk_outs("handler.held", 0, 0, 0, 32'h0, 1);

        // MRET with the request still high -> re-take
        run_ret("ret1", 32'h0000_2004, 1'b1);
        tick(); chk_outs("retake.pend", 0, 0, 0, 32'h0, 0);
        quiet("retake.pend_wait", 10);
        WB_VALID = 1'b1;
        WB_PC_NEXT = 32'h0000_3000;
        tick(); chk_outs("retake.take", 1, 1, 1, 32'h0000_0100, 0);
        chk("retake.int_pc", INT_PC, 32'h0000_3000);
        WB_VALID = 1'b0;
        tick(); chk_outs("retake.handler", 0, 0, 0, 32'h0, 1);
        run_ret("ret2", 32'h0000_3000, 1'b0);
        quiet("ret2.after", 5);

        // masked request
        CSR_MIE = 1'b0;
        INTR = 1'b1;
        WB_VALID = 1'b1;
        WB_PC_NEXT = 32'h0000_4000;
        quiet("masked", 50);
        CSR_MIE = 1'b1;
        tick(); chk_outs("unmask.pend", 0, 0, 0, 32'h0, 0);
        tick(); chk_outs("unmask.take", 1, 1, 1, 32'h0000_0100, 0);
        chk("unmask.int_pc", INT_PC, 32'h0000_4000);
        WB_VALID = 1'b0;
        INTR = 1'b0;
        tick(); chk_outs("unmask.handler", 0, 0, 0, 32'h0, 1);
        run_ret("ret3", 32'h0000_4000, 1'b0);
        quiet("ret3.after", 3);

        // abort from PEND; the retire that coincides with req low must lose
        INTR = 1'b1;
        WB_VALID = 1'b0;
        tick(); tick(); tick();
        quiet("abort.pend_hold", 3);
        INTR = 1'b0;
        tick(); tick();
        WB_VALID = 1'b1;
        WB_PC_NEXT = 32'h0000_6000;
        quiet("abort.no_take", 10);
        chk("abort.int_pc_kept", INT_PC, 32'h0000_4000);
        WB_VALID = 1'b0;

        // stray MRET in IDLE
        CSR_MEPC = 32'h0000_7770;
        WB_VALID = 1'b1;
        WB_MRET = 1'b1;
        quiet("stray_mret", 8);
        WB_VALID = 1'b0;
        WB_MRET = 1'b0;
        run_take("after_stray", 32'h0000_2100);
        run_ret("ret4", 32'h0000_2100, 1'b0);
        quiet("ret4.after", 3);

        // asynchronous reset in the middle of TAKE
        INTR = 1'b1;
        WB_VALID = 1'b1;
        WB_PC_NEXT = 32'h0000_8000;
        tick(); tick(); tick(); tick();
        chk_outs("pre_reset.take", 1, 1, 1, 32'h0000_0100, 0);
        #2;
        RST_N = 1'b0;
        #1;
        chk_outs("mid_reset", 0, 0, 0, 32'h0, 0);
        chk("mid_reset.int_pc", INT_PC, 32'h0);
        INTR = 1'b0;
        WB_VALID = 1'b0;
        #10;
        RST_N = 1'b1;
        quiet("post_reset", 20);
        run_take("post_reset_take", 32'h0000_9000);
        run_ret("ret5", 32'h0000_9000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/otter_intr_ctrl.md
# otter_intr_ctrl

Interrupt/trap sequencer for the OTTER pipeline: the consumer side of the CSR block's MIE/MTVEC/MEPC outputs and the producer of its INT_TAKEN/PC inputs. It synchronizes the external interrupt line, takes the interrupt on an instruction-retire boundary in writeback, flushes and redirects the pipeline to MTVEC, masks further interrupts while the handler runs, and on a retired MRET redirects back to MEPC. It sits beside the writeback stage, drives the hazard/flush logic and the PC-select mux, and feeds INT_TAKEN/INT_PC straight into the CSR block.

## Interface
- SYNC_STAGES, 2, number of flops in the INTR synchronizer (legal values 2 to 4).
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low; clears all state and outputs immediately.
- INTR  in  1  external interrupt request; asynchronous level, active-high.
- CSR_MIE  in  1  interrupt enable from the CSR block.
- CSR_MTVEC  in  32  trap handler address from the CSR block.
- CSR_MEPC  in  32  return address from the CSR block.
- WB_VALID  in  1  a valid instruction retires in writeback this cycle.
- WB_MRET  in  1  the retiring instruction is MRET; qualified by WB_VALID.
- WB_PC_NEXT  in  32  architectural next PC of the retiring instruction (branch target if taken).
- INT_TAKEN  out  1  one-cycle pulse; the CSR block captures MEPC from INT_PC on this.
- INT_PC  out  32  return address saved for the handler; connects to the CSR PC input.
- FLUSH  out  1  one-cycle pulse; kills every instruction younger than writeback.
- REDIRECT  out  1  one-cycle pulse; the PC loads REDIRECT_PC.
- REDIRECT_PC  out  32  redirect target; 0 when REDIRECT is low.
- IN_HANDLER  out  1  high while the handler is executing (interrupts masked).

## Operation
- Synchronizer: INTR passes through SYNC_STAGES flops reset to 0; the last stage is `req`.
- States: IDLE, PEND, TAKE, HANDLER, RET. Reset state is IDLE.
- IDLE: if `req` & CSR_MIE, go to PEND. Otherwise stay. WB_MRET outside the handler is ignored (no redirect).
- PEND: if `req` = 0 or CSR_MIE = 0, abort to IDLE (level-sensitive, nothing saved). Else if WB_VALID = 1, load INT_PC <= WB_PC_NEXT and go to TAKE. Else wait indefinitely.
- TAKE (one cycle): INT_TAKEN = FLUSH = REDIRECT = 1, REDIRECT_PC = CSR_MTVEC; go to HANDLER unconditionally. WB inputs are ignored.
- HANDLER: IN_HANDLER = 1. `req` and CSR_MIE are ignored, so there is no nesting. WB_VALID & WB_MRET goes to RET.
- RET (one cycle): FLUSH = REDIRECT = 1, REDIRECT_PC = CSR_MEPC; go to IDLE. If `req` & CSR_MIE are still high, IDLE goes to PEND on the next edge, so the interrupt is taken again.
- All control outputs decode from the state register (Moore) and are glitch-free. INT_PC is a register that holds its value until the next capture.
- Reset values: INT_TAKEN = FLUSH = REDIRECT = IN_HANDLER = 0, REDIRECT_PC = 0, INT_PC = 0, synchronizer = 0, state = IDLE.
- Widths: all addresses are 32 bits, passed through unmodified. There is no alignment checking.

## Timing
- Interrupt latency with SYNC_STAGES = 2 and INTR set up before edge 1:
  - `req` is high after edge 2.
  - PEND after edge 3.
  - With WB_VALID high before edge 4: TAKE during cycle 4-5 and HANDLER after edge 5.
  - The CSR block samples INT_TAKEN at edge 5.
- Each additional SYNC_STAGES adds one cycle.
- PEND with WB_VALID held low is held with no timeout. When the pipeline is empty, the capture waits for the next retire.
- The WB_MRET in HANDLER to RET transition takes one edge. The REDIRECT pulse lasts exactly one cycle.
- A simultaneous WB_VALID and `req` drop in PEND resolves to abort: the drop has priority.
- Reset mid-operation (any state) clears to IDLE asynchronously; no pulse completes. After release, the synchronizer refills before any new PEND.

## Test plan
- Reset: RST_N = 0 mid-TAKE -> all outputs 0 immediately, state IDLE; after release with INTR = 0, no pulses for 20 cycles.
- Basic take: MIE = 1, MTVEC = 0x0000_0100, INTR raised, WB_VALID with WB_PC_NEXT = 0x0000_2004 -> INT_PC = 0x2004, a one-cycle INT_TAKEN/FLUSH/REDIRECT with REDIRECT_PC = 0x100, then IN_HANDLER = 1; latency matches the Timing section.
- Masked: MIE = 0 with INTR high for 50 cycles -> no PEND and no pulses; setting MIE = 1 -> take proceeds.
- Abort: reach PEND with WB_VALID = 0, drop INTR (after sync) -> return to IDLE; INT_PC keeps its previous value; no pulses.
- Handler and return: in HANDLER, toggle INTR and hold MIE = 1 -> no new take. Then retire MRET with CSR_MEPC = 0x2004 -> one-cycle FLUSH/REDIRECT to 0x2004, IDLE, IN_HANDLER = 0. With INTR still high, a re-take occurs.
- Stray MRET: WB_VALID & WB_MRET in IDLE -> no REDIRECT, no state change.
